// File: rtl/loop_nest_scheduler_if.sv
// Handshake bundle between a pipeline controller and loop_nest_scheduler.
// Ports: start/extents/en (controller side), valid/idx/last/busy/done (scheduler).
interface loop_nest_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3
);
    logic                   start;
    logic [DEPTH*WIDTH-1:0] extents;
    logic                   en;
    logic                   valid;
    logic [DEPTH*WIDTH-1:0] idx;
    logic                   last;
    logic                   busy;
    logic                   done;

    modport master (
        output start, extents, en,
        input  valid, idx, last, busy, done
    );

    modport slave (
        input  start, extents, en,
        output valid, idx, last, busy, done
    );
endinterface

// File: rtl/loop_nest_scheduler.sv
// DEPTH-level loop nest walker: one issue every II enabled cycles, mixed-radix idx.
// Ports: clk, rst (sync, active-low), bus (slave: start/extents/en in; valid/idx/last/busy/done out).
// Option: LOOP_NEST_SCHEDULER_RESTART_EN lets start in RUN abort and restart the nest.
module loop_nest_scheduler #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int II    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    loop_nest_scheduler_if.slave bus
);
    localparam int CW = (II > 1) ? $clog2(II) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0][WIDTH-1:0] ext_q, ext_d;
    logic [DEPTH-1:0][WIDTH-1:0] idx_q, idx_d;
    logic [DEPTH-1:0][WIDTH-1:0] ext_in;
    logic [DEPTH-1:0][WIDTH-1:0] idx_inc;
    logic [DEPTH-1:0]            at_max;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        issue;
    logic                        at_end;
    logic                        ext_zero;

    assign ext_in = bus.extents;

    // Mixed-radix increment: a level wraps and carries only when
    // every lower level is also at its final value.
    always_comb begin
        logic carry;
        carry    = 1'b1;
        ext_zero = 1'b0;
        at_max   = '0;
        idx_inc  = idx_q;
        for (int k = 0; k < DEPTH; k++) begin
            at_max[k] = (idx_q[k] == ext_q[k] - WIDTH'(1));
            if (carry) begin
                idx_inc[k] = at_max[k] ? '0 : idx_q[k] + WIDTH'(1);
            end
            carry = carry & at_max[k];
            if (ext_in[k] == '0) begin
                ext_zero = 1'b1;
            end
        end
    end

    assign at_end = &at_max;
    assign issue  = (state_q == RUN) && bus.en && (cnt_q == '0);

    assign bus.valid = issue;
    assign bus.last  = issue && at_end;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.idx   = idx_q;

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (ext_zero) begin
                        done_d = 1'b1;
                    end else begin
                        ext_d   = ext_in;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.en) begin
                    cnt_d = (cnt_q == CW'(II - 1)) ? '0 : cnt_q + CW'(1);
                    if (issue) begin
                        idx_d = idx_inc;
                        if (at_end) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
`ifdef LOOP_NEST_SCHEDULER_RESTART_EN
                // Restart overrides the normal advance, including a
                // coinciding last issue (which is still shown on valid).
                if (bus.start) begin
                    idx_d = '0;
                    cnt_d = '0;
                    if (ext_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b0;
                        ext_d   = ext_in;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ext_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Self-checking bench for loop_nest_scheduler: two instances (DEPTH=2/II=1, DEPTH=3/II=3).
// Table vectors, directed corner sequences, and random stimulus against a reference model.
module tb_loop_nest_scheduler;
`ifdef LOOP_NEST_SCHEDULER_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   model_on = 1'b0;

    always #5 clk = ~clk;

    loop_nest_scheduler_if #(.WIDTH(16), .DEPTH(2)) a_if ();
    loop_nest_scheduler_if #(.WIDTH(16), .DEPTH(3)) b_if ();

    loop_nest_scheduler #(.WIDTH(16), .DEPTH(2), .II(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    loop_nest_scheduler #(.WIDTH(16), .DEPTH(3), .II(3)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: iteration n of a nest has per-level index
    // (n / prod(lower extents)) % extent; an issue happens on an enabled
    // RUN cycle whose enabled-cycle count is a multiple of II.
    bit    m_busy [2]   = '{0, 0};
    bit    m_dpend[2]   = '{0, 0};
    longint m_n   [2]   = '{0, 0};
    longint m_tot [2]   = '{0, 0};
    longint m_ec  [2]   = '{0, 0};
    longint m_ext [2][3];

    task automatic model(input int d, input int ii, input int depth,
                         input logic st, input logic [47:0] ext,
                         input logic en_i, input logic rs,
                         input logic v, input logic [47:0] ix,
                         input logic l, input logic b, input logic dn);
        string  p;
        bit     ev;
        bit     el;
        longint dv;
        bit     zero;
        logic [15:0] f;
        p  = (d == 0) ? "a" : "b";
        ev = m_busy[d] && en_i && ((m_ec[d] % ii) == 0);
        el = ev && (m_n[d] + 1 == m_tot[d]);
        chk({"m_valid_", p}, 64'(v), 64'(ev));
        chk({"m_last_", p}, 64'(l), 64'(el));
        chk({"m_busy_", p}, 64'(b), 64'(m_busy[d]));
        chk({"m_done_", p}, 64'(dn), 64'(m_dpend[d]));
        if (ev) begin
            dv = 1;
            for (int k = 0; k < depth; k++) begin
                f = ix[k*16 +: 16];
                chk($sformatf("m_idx%0d_%s", k, p), 64'(f),
                    64'((m_n[d] / dv) % m_ext[d][k]));
                dv = dv * m_ext[d][k];
            end
        end
        m_dpend[d] = 1'b0;
        if (!rs) begin
            m_busy[d] = 1'b0;
            m_n[d]    = 0;
            m_ec[d]   = 0;
        end else if (st && (!m_busy[d] || RESTART)) begin
            zero = 1'b0;
            for (int k = 0; k < depth; k++) begin
                f = ext[k*16 +: 16];
                if (f == 0) zero = 1'b1;
            end
            if (zero) begin
                m_busy[d]  = 1'b0;
                m_dpend[d] = 1'b1;
            end else begin
                m_tot[d] = 1;
                for (int k = 0; k < depth; k++) begin
                    f = ext[k*16 +: 16];
                    m_ext[d][k] = longint'(f);
                    m_tot[d] = m_tot[d] * longint'(f);
                end
                m_n[d]    = 0;
                m_ec[d]   = 0;
                m_busy[d] = 1'b1;
            end
        end else if (m_busy[d] && en_i) begin
            if (ev) begin
                m_n[d]++;
                if (m_n[d] == m_tot[d]) begin
                    m_busy[d]  = 1'b0;
                    m_dpend[d] = 1'b1;
                end
            end
            m_ec[d]++;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            model(0, 1, 2, a_if.start, 48'(a_if.extents), a_if.en, rst,
                  a_if.valid, 48'(a_if.idx), a_if.last, a_if.busy, a_if.done);
            model(1, 3, 3, b_if.start, 48'(b_if.extents), b_if.en, rst,
                  b_if.valid, 48'(b_if.idx), b_if.last, b_if.busy, b_if.done);
        end
    end

    function automatic logic [15:0] rext();
        return ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
    endfunction

    typedef struct {
        logic en;
        logic v;
        int   i0;
        int   i1;
        logic l;
        logic b;
        logic d;
    } vec_t;

    vec_t tv[8];

    initial begin
        int vq[$];
        int iq[$];
        int dc;
        int nv;
        int nd;
        int stall;

        tv[0] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0};
        tv[4] = '{1'b1, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1, 2, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        a_if.start = 1'b0; a_if.extents = '0; a_if.en = 1'b0;
        b_if.start = 1'b0; b_if.extents = '0; b_if.en = 1'b0;
        step();
        step();
        model_on = 1'b1;
        #3;
        chk("rst_valid_a", 64'(a_if.valid), 0);
        chk("rst_busy_a", 64'(a_if.busy), 0);
        chk("rst_done_a", 64'(a_if.done), 0);
        chk("rst_idx_a", 64'(a_if.idx), 0);
        chk("rst_last_b", 64'(b_if.last), 0);
        chk("rst_idx_b", 64'(b_if.idx), 0);
        rst = 1'b1;
        step();

        // Table: extents {3,2}, II=1, no stalls.
        a_if.start = 1'b1;
        a_if.extents = {16'd3, 16'd2};
        a_if.en = 1'b1;
        step();
        a_if.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_if.en = tv[i].en;
            #3;
            chk($sformatf("tv%0d_valid", i), 64'(a_if.valid), 64'(tv[i].v));
            if (tv[i].v) begin
                chk($sformatf("tv%0d_idx0", i), 64'(a_if.idx[15:0]), 64'(tv[i].i0));
                chk($sformatf("tv%0d_idx1", i), 64'(a_if.idx[31:16]), 64'(tv[i].i1));
            end
            chk($sformatf("tv%0d_last", i), 64'(a_if.last), 64'(tv[i].l));
            chk($sformatf("tv%0d_busy", i), 64'(a_if.busy), 64'(tv[i].b));
            chk($sformatf("tv%0d_done", i), 64'(a_if.done), 64'(tv[i].d));
            step();
        end

        // II=3 spacing, extents {1,2,2}.
        b_if.start = 1'b1;
        b_if.extents = {16'd1, 16'd2, 16'd2};
        b_if.en = 1'b1;
        step();
        b_if.start = 1'b0;
        vq.delete();
        dc = -1;
        for (int c = 0; c < 40 && dc < 0; c++) begin
            #3;
            if (b_if.valid) vq.push_back(c);
            if (b_if.done) dc = c;
            step();
        end
        chk("ii3_count", 64'(vq.size()), 4);
        for (int j = 0; j < vq.size() && j < 4; j++) begin
            chk($sformatf("ii3_cycle%0d", j), 64'(vq[j]), 64'(3 * j));
        end
        chk("ii3_done_cycle", 64'(dc), 10);

        // Stall of 5 cycles after the 2nd issue, extents {1,1,4}.
        b_if.start = 1'b1;
        b_if.extents = {16'd1, 16'd1, 16'd4};
        step();
        b_if.start = 1'b0;
        iq.delete();
        dc = -1;
        stall = 5;
        for (int c = 0; c < 60 && dc < 0; c++) begin
            b_if.en = 1'b1;
            if (iq.size() >= 2 && stall > 0) begin
                b_if.en = 1'b0;
                stall--;
            end
            #3;
            if (!b_if.en) chk("stall_valid", 64'(b_if.valid), 0);
            if (b_if.valid) iq.push_back(int'(b_if.idx[15:0]));
            if (b_if.done) dc = c;
            step();
        end
        b_if.en = 1'b1;
        chk("stall_count", 64'(iq.size()), 4);
        for (int j = 0; j < iq.size() && j < 4; j++) begin
            chk($sformatf("stall_idx%0d", j), 64'(iq[j]), 64'(j));
        end
        chk("stall_done_seen", 64'(dc >= 0), 1);

        // Zero-trip start, then back-to-back start in the done cycle.
        a_if.start = 1'b1;
        a_if.extents = {16'd0, 16'd5};
        a_if.en = 1'b1;
        step();
        a_if.start = 1'b0;
        #3;
        chk("zero_valid", 64'(a_if.valid), 0);
        chk("zero_busy", 64'(a_if.busy), 0);
        chk("zero_done", 64'(a_if.done), 1);
        a_if.start = 1'b1;
        a_if.extents = {16'd1, 16'd1};
        step();
        a_if.start = 1'b0;
        #3;
        chk("b2b_valid", 64'(a_if.valid), 1);
        chk("b2b_last", 64'(a_if.last), 1);
        chk("b2b_busy", 64'(a_if.busy), 1);
        step();
        #3;
        chk("b2b_done", 64'(a_if.done), 1);
        chk("b2b_idle", 64'(a_if.busy), 0);
        step();

        // Reset after 3 of 8 issues.
        a_if.start = 1'b1;
        a_if.extents = {16'd4, 16'd2};
        step();
        a_if.start = 1'b0;
        nv = 0;
        for (int c = 0; c < 20 && nv < 3; c++) begin
            #3;
            if (a_if.valid) nv++;
            if (nv < 3) step();
        end
        chk("mid_pre_issues", 64'(nv), 3);
        rst = 1'b0;
        step();
        #3;
        chk("mid_rst_valid", 64'(a_if.valid), 0);
        chk("mid_rst_busy", 64'(a_if.busy), 0);
        chk("mid_rst_last", 64'(a_if.last), 0);
        chk("mid_rst_done", 64'(a_if.done), 0);
        chk("mid_rst_idx", 64'(a_if.idx), 0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #3;
            chk("mid_no_done", 64'(a_if.done), 0);
        end
        step();
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        iq.delete();
        dc = -1;
        for (int c = 0; c < 30 && dc < 0; c++) begin
            #3;
            if (a_if.valid) iq.push_back(int'(a_if.idx));
            if (a_if.done) dc = c;
            step();
        end
        chk("rerun_count", 64'(iq.size()), 8);
        if (iq.size() > 0) chk("rerun_first_idx", 64'(iq[0]), 0);
        if (iq.size() == 8) chk("rerun_last_idx", 64'(iq[7]), 64'({16'd3, 16'd1}));

        // Start during RUN: restart or ignore depending on the build.
        a_if.start = 1'b1;
        a_if.extents = {16'd3, 16'd2};
        step();
        a_if.start = 1'b0;
        #3;
        step();
        #3;
        a_if.start = 1'b1;
        a_if.extents = {16'd1, 16'd2};
        step();
        a_if.start = 1'b0;
        nv = 0;
        nd = 0;
        dc = -1;
        iq.delete();
        for (int c = 0; c < 30 && dc < 0; c++) begin
            #3;
            if (a_if.valid) begin
                nv++;
                iq.push_back(int'(a_if.idx[15:0]));
            end
            if (a_if.done) begin
                nd++;
                dc = c;
            end
            step();
        end
        chk("rs_valids", 64'(nv), RESTART ? 2 : 4);
        chk("rs_done_count", 64'(nd), 1);
        if (iq.size() > 0) chk("rs_first_idx0", 64'(iq[0]), RESTART ? 0 : 0);
        if (iq.size() > 1) chk("rs_second_idx0", 64'(iq[1]), 1);

        // Random traffic on both instances, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            a_if.en = ($urandom_range(0, 3) != 0);
            b_if.en = ($urandom_range(0, 3) != 0);
            a_if.extents = {rext(), rext()};
            b_if.extents = {rext(), rext(), rext()};
            a_if.start = a_if.busy ? ($urandom_range(0, 29) == 0)
                                   : ($urandom_range(0, 3) == 0);
            b_if.start = b_if.busy ? ($urandom_range(0, 59) == 0)
                                   : ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b1;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
